ipsxb_seu_uart_rx: RTL and testbench

IPSXB_SEU_UART_RX -- requirements
Module: ipsxb_seu_uart_rx

---
 rtl/ipsxb_seu_uart_rx_if.sv | 29 ++
 rtl/ipsxb_seu_uart_rx.sv | 200 ++++++++++++++++++++
 tb/tb_ipsxb_seu_uart_rx.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/ipsxb_seu_uart_rx_if.sv
// Receive-side FIFO write port and status pulses of the 32-bit UART receiver.
// The receiver is the master: it drives the write strobe, data and flags,
// and the downstream FIFO answers with its full indication.
interface ipsxb_seu_uart_rx_if;
   logic        rx_fifo_full;
   logic [31:0] rx_fifo_wr_data;
   logic        rx_fifo_wr_en;
   logic        rx_frame_err;
   logic        rx_overflow;
   logic        rx_timeout;

   modport master (
      input  rx_fifo_full,
      output rx_fifo_wr_data,
      output rx_fifo_wr_en,
      output rx_frame_err,
      output rx_overflow,
      output rx_timeout
   );

   modport slave (
      output rx_fifo_full,
      input  rx_fifo_wr_data,
      input  rx_fifo_wr_en,
      input  rx_frame_err,
      input  rx_overflow,
      input  rx_timeout
   );
endinterface

// File: rtl/ipsxb_seu_uart_rx.sv
// 32-bit word UART receiver.
// Collects four back-to-back 8N1 bytes (LSB first, first byte in word bits
// [7:0]) from an oversampled serial line and writes the assembled word into a
// downstream FIFO. Stop-bit errors, FIFO overflow and idle timeouts on a
// partially received word are reported as one-clock pulses.
module ipsxb_seu_uart_rx #(
   parameter int BIT_TICKS     = 6,
   parameter int SAMPLE_TICK   = 3,
   parameter int TIMEOUT_TICKS = 60
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   clk_en,
   input  logic                   rxd,
   ipsxb_seu_uart_rx_if.master    fifo
);

   localparam int TW = (BIT_TICKS > 1) ? $clog2(BIT_TICKS) : 1;
   localparam int OW = (TIMEOUT_TICKS > 1) ? $clog2(TIMEOUT_TICKS + 1) : 1;

   localparam logic [TW-1:0] TCNT_LAST   = TW'(BIT_TICKS - 1);
   localparam logic [TW-1:0] SAMPLE_LAST = TW'(SAMPLE_TICK - 1);
   localparam logic [OW-1:0] OCNT_LAST   = OW'(TIMEOUT_TICKS - 1);

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      STOP,
      ERR
   } state_t;

   logic          rxd_meta;
   logic          rxd_s;

   state_t        state,       state_nxt;
   logic [TW-1:0] tcnt,        tcnt_nxt;
   logic [2:0]    bcnt,        bcnt_nxt;
   logic [1:0]    bidx,        bidx_nxt;
   logic [7:0]    shift_q,     shift_nxt;
   logic [23:0]   word_q,      word_nxt;
   logic [OW-1:0] to_cnt,      to_cnt_nxt;
   logic [31:0]   wr_data_q,   wr_data_nxt;
   logic          wr_en_q,     wr_en_nxt;
   logic          frame_err_q, frame_err_nxt;
   logic          overflow_q,  overflow_nxt;
   logic          timeout_q,   timeout_nxt;

   // Two-flop synchronizer for the asynchronous line; idles high out of reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         rxd_meta <= 1'b1;
         rxd_s    <= 1'b1;
      end else begin
         rxd_meta <= rxd;
         rxd_s    <= rxd_meta;
      end
   end

   // Next-state, counter, assembly and pulse logic; nothing moves without clk_en.
   always_comb begin
      state_nxt     = state;
      tcnt_nxt      = tcnt;
      bcnt_nxt      = bcnt;
      bidx_nxt      = bidx;
      shift_nxt     = shift_q;
      word_nxt      = word_q;
      to_cnt_nxt    = to_cnt;
      wr_data_nxt   = wr_data_q;
      wr_en_nxt     = 1'b0;
      frame_err_nxt = 1'b0;
      overflow_nxt  = 1'b0;
      timeout_nxt   = 1'b0;

      if (clk_en) begin
         case (state)
            IDLE: begin
               if (!rxd_s) begin
                  state_nxt  = START;
                  tcnt_nxt   = '0;
                  to_cnt_nxt = '0;
               end else if (bidx != 2'd0) begin
                  if (to_cnt == OCNT_LAST) begin
                     timeout_nxt = 1'b1;
                     bidx_nxt    = 2'd0;
                     to_cnt_nxt  = '0;
                  end else begin
                     to_cnt_nxt = to_cnt + OW'(1);
                  end
               end else begin
                  to_cnt_nxt = '0;
               end
            end

            START: begin
               if (tcnt == SAMPLE_LAST) begin
                  if (rxd_s) begin
                     state_nxt = IDLE;
                  end else begin
                     state_nxt = DATA;
                     tcnt_nxt  = '0;
                     bcnt_nxt  = 3'd0;
                  end
               end else begin
                  tcnt_nxt = tcnt + TW'(1);
               end
            end

            DATA: begin
               if (tcnt == TCNT_LAST) begin
                  tcnt_nxt  = '0;
                  shift_nxt = {rxd_s, shift_q[7:1]};
                  bcnt_nxt  = bcnt + 3'd1;
                  if (bcnt == 3'd7) begin
                     state_nxt = STOP;
                  end
               end else begin
                  tcnt_nxt = tcnt + TW'(1);
               end
            end

            STOP: begin
               if (tcnt == TCNT_LAST) begin
                  if (rxd_s) begin
                     state_nxt = IDLE;
                     bidx_nxt  = bidx + 2'd1;
                     case (bidx)
                        2'd0: word_nxt[7:0]   = shift_q;
                        2'd1: word_nxt[15:8]  = shift_q;
                        2'd2: word_nxt[23:16] = shift_q;
                        default: begin
                           if (fifo.rx_fifo_full) begin
                              overflow_nxt = 1'b1;
                           end else begin
                              wr_en_nxt   = 1'b1;
                              wr_data_nxt = {shift_q, word_q};
                           end
                        end
                     endcase
                  end else begin
                     frame_err_nxt = 1'b1;
                     bidx_nxt      = 2'd0;
                     state_nxt     = ERR;
                  end
               end else begin
                  tcnt_nxt = tcnt + TW'(1);
               end
            end

            ERR: begin
               if (rxd_s) begin
                  state_nxt = IDLE;
               end
            end

            default: begin
               state_nxt = IDLE;
            end
         endcase
      end
   end

   // State, counters, assembled data and the registered output pulses.
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         tcnt        <= '0;
         bcnt        <= 3'd0;
         bidx        <= 2'd0;
         shift_q     <= 8'd0;
         word_q      <= 24'd0;
         to_cnt      <= '0;
         wr_data_q   <= 32'd0;
         wr_en_q     <= 1'b0;
         frame_err_q <= 1'b0;
         overflow_q  <= 1'b0;
         timeout_q   <= 1'b0;
      end else begin
         state       <= state_nxt;
         tcnt        <= tcnt_nxt;
         bcnt        <= bcnt_nxt;
         bidx        <= bidx_nxt;
         shift_q     <= shift_nxt;
         word_q      <= word_nxt;
         to_cnt      <= to_cnt_nxt;
         wr_data_q   <= wr_data_nxt;
         wr_en_q     <= wr_en_nxt;
         frame_err_q <= frame_err_nxt;
         overflow_q  <= overflow_nxt;
         timeout_q   <= timeout_nxt;
      end
   end

   assign fifo.rx_fifo_wr_data = wr_data_q;
   assign fifo.rx_fifo_wr_en   = wr_en_q;
   assign fifo.rx_frame_err    = frame_err_q;
   assign fifo.rx_overflow     = overflow_q;
   assign fifo.rx_timeout      = timeout_q;

endmodule

// File: tb/tb_ipsxb_seu_uart_rx.sv
// Directed bench for the 32-bit UART receiver: serialises known words on rxd,
// counts the pulses the receiver emits and compares against hand-derived values.
module tb_ipsxb_seu_uart_rx;

   localparam int BIT_TICKS = 6;

   logic clk;
   logic rst;
   logic clk_en;
   logic rxd;

   int enDiv = 1;
   int divCnt = 0;

   int assertCount = 0;
   int failCount = 0;

   int wrCount = 0;
   int ferrCount = 0;
   int ovfCount = 0;
   int toCount = 0;

   int wrBase, ferrBase, ovfBase, toBase;

   ipsxb_seu_uart_rx_if fifo_if();

   ipsxb_seu_uart_rx #(
      .BIT_TICKS(6),
      .SAMPLE_TICK(3),
      .TIMEOUT_TICKS(60)
   ) dut (
      .clk(clk),
      .rst(rst),
      .clk_en(clk_en),
      .rxd(rxd),
      .fifo(fifo_if)
   );

   // Free-running 100 MHz clock.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Oversample enable: high one clock in every enDiv clocks.
   initial begin
      clk_en = 1'b0;
      forever begin
         @(negedge clk);
         if (divCnt >= enDiv - 1) begin
            clk_en = 1'b1;
            divCnt = 0;
         end else begin
            clk_en = 1'b0;
            divCnt++;
         end
      end
   end

   // Pulse counters, sampled on the falling edge away from the active edge.
   always @(negedge clk) begin
      if (fifo_if.rx_fifo_wr_en === 1'b1) wrCount++;
      if (fifo_if.rx_frame_err === 1'b1) ferrCount++;
      if (fifo_if.rx_overflow === 1'b1) ovfCount++;
      if (fifo_if.rx_timeout === 1'b1) toCount++;
   end

   // Safety net so the run always ends.
   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      assertCount++;
      if (got !== exp) begin
         failCount++;
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic markCounts();
      wrBase   = wrCount;
      ferrBase = ferrCount;
      ovfBase  = ovfCount;
      toBase   = toCount;
   endtask

   task automatic waitTicks(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         while (clk_en !== 1'b1) @(posedge clk);
      end
   endtask

   task automatic applyStimulus(input logic b, input int nTicks);
      @(negedge clk);
      rxd = b;
      waitTicks(nTicks);
   endtask

   task automatic sendByte(input logic [7:0] b, input logic stopVal);
      applyStimulus(1'b0, BIT_TICKS);
      for (int i = 0; i < 8; i++) applyStimulus(b[i], BIT_TICKS);
      applyStimulus(stopVal, BIT_TICKS);
   endtask

   task automatic sendWord(input logic [31:0] w);
      for (int i = 0; i < 4; i++) sendByte(w[8*i +: 8], 1'b1);
      applyStimulus(1'b1, 1);
   endtask

   initial begin
      rst = 1'b1;
      rxd = 1'b1;
      fifo_if.rx_fifo_full = 1'b0;
      repeat (3) @(negedge clk);

      // Reset state of every output.
      checkOutput("reset_wr_data", fifo_if.rx_fifo_wr_data, 32'h0);
      checkOutput("reset_wr_en", {31'd0, fifo_if.rx_fifo_wr_en}, 32'h0);
      checkOutput("reset_frame_err", {31'd0, fifo_if.rx_frame_err}, 32'h0);
      checkOutput("reset_overflow", {31'd0, fifo_if.rx_overflow}, 32'h0);
      checkOutput("reset_timeout", {31'd0, fifo_if.rx_timeout}, 32'h0);
      rst = 1'b0;
      applyStimulus(1'b1, 10);

      // Plain word at full oversample rate.
      markCounts();
      sendWord(32'h12345678);
      applyStimulus(1'b1, 10);
      checkOutput("word1_wr_pulses", wrCount - wrBase, 1);
      checkOutput("word1_data", fifo_if.rx_fifo_wr_data, 32'h12345678);
      checkOutput("word1_frame_err", ferrCount - ferrBase, 0);
      checkOutput("word1_overflow", ovfCount - ovfBase, 0);
      checkOutput("word1_timeout", toCount - toBase, 0);

      // Two-tick low glitch on an idle line.
      markCounts();
      applyStimulus(1'b0, 2);
      applyStimulus(1'b1, 20);
      checkOutput("glitch_wr_pulses", wrCount - wrBase, 0);
      checkOutput("glitch_frame_err", ferrCount - ferrBase, 0);
      checkOutput("glitch_timeout", toCount - toBase, 0);

      // Stop bit of byte 2 low, line then held low, then a good word.
      markCounts();
      sendByte(8'h01, 1'b1);
      sendByte(8'h02, 1'b1);
      sendByte(8'h03, 1'b0);
      applyStimulus(1'b0, 3 * BIT_TICKS);
      applyStimulus(1'b1, 20);
      checkOutput("ferr_pulses", ferrCount - ferrBase, 1);
      checkOutput("ferr_wr_pulses", wrCount - wrBase, 0);
      sendWord(32'hA5A50FF0);
      applyStimulus(1'b1, 10);
      checkOutput("ferr_next_wr_pulses", wrCount - wrBase, 1);
      checkOutput("ferr_next_data", fifo_if.rx_fifo_wr_data, 32'hA5A50FF0);
      checkOutput("ferr_total_pulses", ferrCount - ferrBase, 1);
      checkOutput("ferr_timeout", toCount - toBase, 0);

      // Word completes while the FIFO is full.
      markCounts();
      fifo_if.rx_fifo_full = 1'b1;
      sendWord(32'hDEADBEEF);
      applyStimulus(1'b1, 10);
      fifo_if.rx_fifo_full = 1'b0;
      checkOutput("ovf_pulses", ovfCount - ovfBase, 1);
      checkOutput("ovf_wr_pulses", wrCount - wrBase, 0);
      checkOutput("ovf_data_held", fifo_if.rx_fifo_wr_data, 32'hA5A50FF0);

      // Two bytes then idle: discarded after the timeout, next word clean.
      markCounts();
      sendByte(8'h11, 1'b1);
      sendByte(8'h22, 1'b1);
      applyStimulus(1'b1, 50);
      checkOutput("timeout_early", toCount - toBase, 0);
      applyStimulus(1'b1, 20);
      checkOutput("timeout_pulses", toCount - toBase, 1);
      checkOutput("timeout_wr_pulses", wrCount - wrBase, 0);
      sendWord(32'h01020304);
      applyStimulus(1'b1, 10);
      checkOutput("timeout_next_wr", wrCount - wrBase, 1);
      checkOutput("timeout_next_data", fifo_if.rx_fifo_wr_data, 32'h01020304);

      // Enable one clock in three, reset in the middle of a byte.
      enDiv = 3;
      applyStimulus(1'b1, 5);
      markCounts();
      sendByte(8'h77, 1'b1);
      applyStimulus(1'b0, BIT_TICKS);
      applyStimulus(1'b1, BIT_TICKS);
      applyStimulus(1'b0, BIT_TICKS);
      @(negedge clk);
      rst = 1'b1;
      rxd = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      checkOutput("rst_mid_data", fifo_if.rx_fifo_wr_data, 32'h0);
      applyStimulus(1'b1, 10);
      sendWord(32'hCAFEBABE);
      applyStimulus(1'b1, 10);
      checkOutput("slow_wr_pulses", wrCount - wrBase, 1);
      checkOutput("slow_data", fifo_if.rx_fifo_wr_data, 32'hCAFEBABE);
      checkOutput("slow_frame_err", ferrCount - ferrBase, 0);
      checkOutput("slow_overflow", ovfCount - ovfBase, 0);
      checkOutput("slow_timeout", toCount - toBase, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

endmodule
